// File: rtl/gate_reduce_stream.sv
// Streaming AND/OR/XOR reduction over framed WIDTH-bit beats.
// Results and the beat count are presented on a registered valid/ready output.
module gate_reduce_stream #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned BEATS = 4,
    parameter int unsigned CW    = $clog2(BEATS + 1)
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             and_out,
    output logic             or_out,
    output logic             xor_out,
    output logic [CW-1:0]    beats_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state, state_d;
    logic            acc_and, acc_or, acc_xor;
    logic            acc_and_d, acc_or_d, acc_xor_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic            out_valid_d, and_out_d, or_out_d, xor_out_d;
    logic [CW-1:0]   beats_out_d;

    logic            accept;
    logic            beat_and, beat_or, beat_xor;
    logic [CW-1:0]   cnt_inc;

    assign in_ready = reset_L && (state != HOLD);
    assign accept   = in_valid && in_ready;
    assign beat_and = &in_data;
    assign beat_or  = |in_data;
    assign beat_xor = ^in_data;
    assign cnt_inc  = cnt + CW'(1);

    // Next-state and next-output logic; closing a frame loads the result registers.
    always_comb begin
        state_d     = state;
        acc_and_d   = acc_and;
        acc_or_d    = acc_or;
        acc_xor_d   = acc_xor;
        cnt_d       = cnt;
        out_valid_d = out_valid;
        and_out_d   = and_out;
        or_out_d    = or_out;
        xor_out_d   = xor_out;
        beats_out_d = beats_out;

        case (state)
            IDLE: begin
                if (accept) begin
                    acc_and_d = beat_and;
                    acc_or_d  = beat_or;
                    acc_xor_d = beat_xor;
                    cnt_d     = CW'(1);
                    if (in_last || (BEATS == 1)) begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                        and_out_d   = beat_and;
                        or_out_d    = beat_or;
                        xor_out_d   = beat_xor;
                        beats_out_d = CW'(1);
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_and_d = acc_and & beat_and;
                    acc_or_d  = acc_or | beat_or;
                    acc_xor_d = acc_xor ^ beat_xor;
                    cnt_d     = cnt_inc;
                    if (in_last || (cnt_inc == CW'(BEATS))) begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                        and_out_d   = acc_and & beat_and;
                        or_out_d    = acc_or | beat_or;
                        xor_out_d   = acc_xor ^ beat_xor;
                        beats_out_d = cnt_inc;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            acc_and   <= 1'b0;
            acc_or    <= 1'b0;
            acc_xor   <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            and_out   <= 1'b0;
            or_out    <= 1'b0;
            xor_out   <= 1'b0;
            beats_out <= '0;
        end else begin
            state     <= state_d;
            acc_and   <= acc_and_d;
            acc_or    <= acc_or_d;
            acc_xor   <= acc_xor_d;
            cnt       <= cnt_d;
            out_valid <= out_valid_d;
            and_out   <= and_out_d;
            or_out    <= or_out_d;
            xor_out   <= xor_out_d;
            beats_out <= beats_out_d;
        end
    end

endmodule

// File: tb/tb_gate_reduce_stream.sv
// Self-checking bench for gate_reduce_stream (WIDTH=4, BEATS=4).
// Expected frame results are queued on stimulus and compared at each output handshake.
module tb_gate_reduce_stream;

    typedef struct packed {
        logic       a;
        logic       o;
        logic       x;
        logic [2:0] b;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic       and_out;
    logic       or_out;
    logic       xor_out;
    logic [2:0] beats_out;

    int   passed = 0;
    int   total  = 0;
    exp_t q[$];

    wire [6:0] obs = {out_valid, and_out, or_out, xor_out, beats_out};

    gate_reduce_stream #(.WIDTH(4), .BEATS(4)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .and_out   (and_out),
        .or_out    (or_out),
        .xor_out   (xor_out),
        .beats_out (beats_out)
    );

    always #5 clk = ~clk;

    // Scoreboard: compare at the negedge preceding each output handshake.
    always @(negedge clk) begin
        if (reset_L && out_valid) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL spurious_out_valid: got out_valid=1 with no frame pending");
            end else if (out_ready) begin
                exp_t e;
                e = q.pop_front();
                total++;
                if ({and_out, or_out, xor_out, beats_out} !== e) begin
                    $display("FAIL scoreboard: got and=%b or=%b xor=%b beats=%0d exp and=%b or=%b xor=%b beats=%0d",
                             and_out, or_out, xor_out, beats_out, e.a, e.o, e.x, e.b);
                end else begin
                    passed++;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            total++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset;
        reset_L = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'($urandom);
            in_data   = 4'($urandom);
            in_last   = 1'($urandom);
            out_ready = 1'($urandom);
            tick();
            total++;
            if ({obs, in_ready} !== 8'b0) begin
                $display("FAIL reset_state: got %b exp %b", {obs, in_ready}, 8'b0);
            end else begin
                passed++;
            end
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        reset_L   = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_release_ready: got %b exp 1", in_ready);
        end else begin
            passed++;
        end
    endtask

    task automatic test_full_frame;
        out_ready = 1'b1;
        q.push_back('{a: 1'b0, o: 1'b1, x: 1'b0, b: 3'd4});
        send(4'b0111, 1'b0);
        send(4'b0000, 1'b0);
        send(4'b1111, 1'b0);
        send(4'b0010, 1'b0);
        total++;
        if ({obs, in_ready} !== {1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0}) begin
            $display("FAIL full_result: got %b exp %b", {obs, in_ready}, {1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0});
        end else begin
            passed++;
        end
        tick();
        total++;
        if (obs !== {1'b0, 1'b0, 1'b1, 1'b0, 3'd4}) begin
            $display("FAIL full_drop: got %b exp %b", obs, {1'b0, 1'b0, 1'b1, 1'b0, 3'd4});
        end else begin
            passed++;
        end
    endtask

    task automatic test_early_close;
        out_ready = 1'b1;
        q.push_back('{a: 1'b1, o: 1'b1, x: 1'b0, b: 3'd1});
        send(4'b1111, 1'b1);
        total++;
        if (obs !== {1'b1, 1'b1, 1'b1, 1'b0, 3'd1}) begin
            $display("FAIL early_1111: got %b exp %b", obs, {1'b1, 1'b1, 1'b1, 1'b0, 3'd1});
        end else begin
            passed++;
        end
        tick();
        q.push_back('{a: 1'b0, o: 1'b1, x: 1'b1, b: 3'd1});
        send(4'b0001, 1'b1);
        total++;
        if (obs !== {1'b1, 1'b0, 1'b1, 1'b1, 3'd1}) begin
            $display("FAIL early_0001: got %b exp %b", obs, {1'b1, 1'b0, 1'b1, 1'b1, 3'd1});
        end else begin
            passed++;
        end
        tick();
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        q.push_back('{a: 1'b0, o: 1'b1, x: 1'b0, b: 3'd4});
        send(4'b0111, 1'b0);
        send(4'b0000, 1'b0);
        send(4'b1111, 1'b0);
        send(4'b0010, 1'b0);
        q.push_back('{a: 1'b1, o: 1'b1, x: 1'b0, b: 3'd1});
        in_valid = 1'b1;
        in_data  = 4'b1111;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({obs, in_ready} !== {1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0}) begin
                $display("FAIL bp_hold%0d: got %b exp %b", i, {obs, in_ready}, {1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0});
            end else begin
                passed++;
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            $display("FAIL bp_release: got valid/ready %b exp 01", {out_valid, in_ready});
        end else begin
            passed++;
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        total++;
        if (obs !== {1'b1, 1'b1, 1'b1, 1'b0, 3'd1}) begin
            $display("FAIL bp_next_beat: got %b exp %b", obs, {1'b1, 1'b1, 1'b1, 1'b0, 3'd1});
        end else begin
            passed++;
        end
        tick();
    endtask

    task automatic test_gaps;
        logic [3:0] beats [4];
        beats = '{4'b0111, 4'b0000, 4'b1111, 4'b0010};
        out_ready = 1'b1;
        q.push_back('{a: 1'b0, o: 1'b1, x: 1'b0, b: 3'd4});
        for (int i = 0; i < 4; i++) begin
            send(beats[i], 1'b0);
            if (i < 3) begin
                tick();
                tick();
            end
        end
        total++;
        if (obs !== {1'b1, 1'b0, 1'b1, 1'b0, 3'd4}) begin
            $display("FAIL gaps_result: got %b exp %b", obs, {1'b1, 1'b0, 1'b1, 1'b0, 3'd4});
        end else begin
            passed++;
        end
        tick();
    endtask

    task automatic test_reset_mid_frame;
        out_ready = 1'b1;
        send(4'b0000, 1'b0);
        send(4'b0101, 1'b0);
        #3;
        reset_L = 1'b0;
        #1;
        total++;
        if ({obs, in_ready} !== 8'b0) begin
            $display("FAIL mid_reset_state: got %b exp %b", {obs, in_ready}, 8'b0);
        end else begin
            passed++;
        end
        #1;
        reset_L = 1'b1;
        tick();
        q.push_back('{a: 1'b1, o: 1'b1, x: 1'b0, b: 3'd4});
        for (int i = 0; i < 4; i++) send(4'b1111, 1'b0);
        total++;
        if (obs !== {1'b1, 1'b1, 1'b1, 1'b0, 3'd4}) begin
            $display("FAIL mid_reset_fresh: got %b exp %b", obs, {1'b1, 1'b1, 1'b1, 1'b0, 3'd4});
        end else begin
            passed++;
        end
        tick();
    endtask

    task automatic test_random_frames;
        out_ready = 1'b1;
        for (int f = 0; f < 8; f++) begin
            int   len;
            exp_t e;
            logic [3:0] d;
            logic last;
            len = int'($urandom_range(1, 4));
            e = '{a: 1'b1, o: 1'b0, x: 1'b0, b: 3'(len)};
            for (int i = 0; i < len; i++) begin
                d = 4'($urandom);
                for (int k = 0; k < 4; k++) begin
                    e.a = e.a && d[k];
                    e.o = e.o || d[k];
                    e.x = e.x != d[k];
                end
            end
            q.push_back(e);
            for (int i = 0; i < len; i++) begin
                d = 4'($urandom);
                last = (i == len - 1) && ((len < 4) || ($urandom_range(0, 1) == 1));
                send(d, last);
                if ($urandom_range(0, 1) == 1 && i < len - 1) tick();
            end
            tick();
        end
    endtask

    // Random frames regenerate their data, so rebuild the model from a stored sequence.
    task automatic test_random;
        out_ready = 1'b1;
        for (int f = 0; f < 8; f++) begin
            int         len;
            exp_t       e;
            logic [3:0] d [4];
            logic       last;
            len = int'($urandom_range(1, 4));
            e = '{a: 1'b1, o: 1'b0, x: 1'b0, b: 3'(len)};
            for (int i = 0; i < len; i++) begin
                d[i] = 4'($urandom);
                for (int k = 0; k < 4; k++) begin
                    e.a = e.a && d[i][k];
                    e.o = e.o || d[i][k];
                    e.x = e.x != d[i][k];
                end
            end
            q.push_back(e);
            for (int i = 0; i < len; i++) begin
                last = (i == len - 1) && ((len < 4) || ($urandom_range(0, 1) == 1));
                send(d[i], last);
                if ($urandom_range(0, 1) == 1 && i < len - 1) tick();
            end
            tick();
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        reset_L   = 1'b0;
        #2;
        test_reset();
        test_full_frame();
        test_early_close();
        test_backpressure();
        test_gaps();
        test_reset_mid_frame();
        test_random();
        for (int n = 0; n < 100 && q.size() != 0; n++) tick();
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d frames outstanding, required 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
